// File: rtl/led_trail_pwm_if.sv
// rtl/led_trail_pwm_if.sv - LED pattern in / PWM drive out bundle for led_trail_pwm
interface led_trail_pwm_if;
   logic [7:0] led_in;
   logic [7:0] led_pwm;
   logic       trail_busy;

   modport master (output led_in, input  led_pwm, input  trail_busy);
   modport slave  (input  led_in, output led_pwm, output trail_busy);
endinterface

// File: rtl/led_trail_pwm.sv
// rtl/led_trail_pwm.sv - per-channel PWM with fading comet tail behind the flow LED
// Optional macro INVERT_OUT_EN: active-low led_pwm (reset value 8'hFF).
module led_trail_pwm #(
   parameter int                  PWM_BITS   = 4,
   parameter logic [23:0]         DECAY_DIV  = 24'd2,
   parameter logic [PWM_BITS-1:0] DECAY_STEP = PWM_BITS'(2)
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   led_trail_pwm_if.slave   bus
);

   localparam logic [PWM_BITS-1:0] LMAX    = '1;
   localparam logic [PWM_BITS-1:0] PWM_TOP = LMAX - PWM_BITS'(1);

`ifdef INVERT_OUT_EN
   localparam logic [7:0] OUT_POL = 8'hFF;
`else
   localparam logic [7:0] OUT_POL = 8'h00;
`endif

   logic [PWM_BITS-1:0] r_pwm_cnt;
   logic [23:0]         r_dec_cnt;
   logic [PWM_BITS-1:0] r_level [8];
   logic [7:0]          r_led_pwm;
   logic                r_trail_busy;

   logic                w_tick;
   logic [7:0]          w_cmp;
   logic                w_any;

   assign w_tick = (r_dec_cnt == DECAY_DIV);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_pwm_cnt <= '0;
         r_dec_cnt <= '0;
      end else begin
         r_pwm_cnt <= (r_pwm_cnt == PWM_TOP) ? '0 : r_pwm_cnt + PWM_BITS'(1);
         r_dec_cnt <= w_tick ? '0 : r_dec_cnt + 24'd1;
      end
   end

   // A lit input wins over a coincident decay tick; decay saturates at zero.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         for (int i = 0; i < 8; i++) begin
            r_level[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (bus.led_in[i]) begin
               r_level[i] <= LMAX;
            end else if (w_tick) begin
               r_level[i] <= (r_level[i] > DECAY_STEP) ? r_level[i] - DECAY_STEP : '0;
            end
         end
      end
   end

   always_comb begin
      w_cmp = '0;
      w_any = 1'b0;
      for (int i = 0; i < 8; i++) begin
         w_cmp[i] = (r_level[i] > r_pwm_cnt);
         w_any    = w_any | (r_level[i] != '0);
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_led_pwm    <= OUT_POL;
         r_trail_busy <= 1'b0;
      end else begin
         r_led_pwm    <= w_cmp ^ OUT_POL;
         r_trail_busy <= w_any;
      end
   end

   assign bus.led_pwm    = r_led_pwm;
   assign bus.trail_busy = r_trail_busy;

endmodule

// File: tb/tb_led_trail_pwm.sv
// tb/tb_led_trail_pwm.sv - directed checks for led_trail_pwm (default and DECAY_STEP=4)
module tb_led_trail_pwm;

   logic sys_clk   = 1'b0;
   logic sys_rst_n = 1'b0;
   always #5 sys_clk = ~sys_clk;

   led_trail_pwm_if bus_a ();
   led_trail_pwm_if bus_b ();

   led_trail_pwm u_dut_a (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus_a)
   );

   led_trail_pwm #(.DECAY_STEP(4'd4)) u_dut_b (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus_b)
   );

`ifdef INVERT_OUT_EN
   localparam logic [7:0] INV = 8'hFF;
`else
   localparam logic [7:0] INV = 8'h00;
`endif

   int n_run  = 0;
   int n_fail = 0;

   // level[3] after edge n: pulse at edge 1, re-lit on the tick at edge 12
   int prio_lvl [21] = '{0, 15, 15, 13, 13, 13, 11, 11, 11, 9, 9, 9,
                         15, 15, 15, 13, 13, 13, 11, 11, 11};

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_run++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h, want %02h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [7:0] v);
      bus_a.led_in = v;
      bus_b.led_in = v;
   endtask

   task automatic reset_with(input logic [7:0] v);
      @(negedge sys_clk);
      sys_rst_n = 1'b0;
      drive(v);
      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b1;
   endtask

   task automatic step();
      @(posedge sys_clk);
      @(negedge sys_clk);
   endtask

   function automatic int fade2(input int n);
      int k;
      if (n == 0) return 0;
      k = n / 3;
      return (k >= 8) ? 0 : 15 - 2 * k;
   endfunction

   function automatic int fade4(input int n);
      int k;
      if (n == 0) return 0;
      k = n / 3;
      return (k >= 4) ? 0 : 15 - 4 * k;
   endfunction

   logic [7:0] exp_v;
   logic [7:0] pat;

   initial begin
      drive(8'h00);

      // static on, then asynchronous reset mid-cycle
      reset_with(8'h01);
      for (int n = 1; n <= 20; n++) begin
         drive(8'h01);
         step();
         chk($sformatf("static_pwm%0d", n), bus_a.led_pwm, ((n == 1) ? 8'h00 : 8'h01) ^ INV);
         chk($sformatf("static_busy%0d", n), {7'b0, bus_a.trail_busy}, (n == 1) ? 8'h00 : 8'h01);
      end
      @(posedge sys_clk);
      #3 sys_rst_n = 1'b0;
      #1;
      chk("async_rst_pwm", bus_a.led_pwm, INV);
      chk("async_rst_busy", {7'b0, bus_a.trail_busy}, 8'h00);

      // single pulse fade: step 2 on dut_a, step 4 on dut_b
      reset_with(8'h01);
      for (int n = 1; n <= 30; n++) begin
         drive((n == 1) ? 8'h01 : 8'h00);
         step();
         exp_v = {7'b0, fade2(n - 1) > ((n - 1) % 15)} ^ INV;
         chk($sformatf("fade2_pwm%0d", n), bus_a.led_pwm, exp_v);
         chk($sformatf("fade2_busy%0d", n), {7'b0, bus_a.trail_busy}, {7'b0, fade2(n - 1) != 0});
         exp_v = {7'b0, fade4(n - 1) > ((n - 1) % 15)} ^ INV;
         chk($sformatf("fade4_pwm%0d", n), bus_b.led_pwm, exp_v);
         chk($sformatf("fade4_busy%0d", n), {7'b0, bus_b.trail_busy}, {7'b0, fade4(n - 1) != 0});
      end

      // input on a tick cycle beats the decrement
      reset_with(8'h08);
      for (int n = 1; n <= 20; n++) begin
         drive((n == 1 || n == 12) ? 8'h08 : 8'h00);
         step();
         exp_v = {4'b0, prio_lvl[n - 1] > ((n - 1) % 15), 3'b0} ^ INV;
         chk($sformatf("prio_pwm%0d", n), bus_a.led_pwm, exp_v);
      end

      // reset while a tail is fading leaves nothing behind
      @(posedge sys_clk);
      #2 sys_rst_n = 1'b0;
      #1;
      chk("midfade_rst_pwm", bus_a.led_pwm, INV);
      chk("midfade_rst_busy", {7'b0, bus_a.trail_busy}, 8'h00);
      drive(8'h00);
      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      for (int n = 1; n <= 6; n++) begin
         step();
         chk($sformatf("midfade_post_pwm%0d", n), bus_a.led_pwm, INV);
         chk($sformatf("midfade_post_busy%0d", n), {7'b0, bus_a.trail_busy}, 8'h00);
      end

      // rotating flow pattern, one position per 3 clocks
      reset_with(8'h01);
      for (int n = 1; n <= 37; n++) begin
         pat = 8'h01 << (((n - 1) / 3) % 8);
         drive(pat);
         step();
         if (n == 28) chk("flow_e28", bus_a.led_pwm, 8'h81 ^ INV);
         if (n == 31) chk("flow_e31", bus_a.led_pwm, 8'hFF ^ INV);
         if (n == 37) begin
            chk("flow_e37", bus_a.led_pwm, 8'h8F ^ INV);
            chk("flow_busy", {7'b0, bus_a.trail_busy}, 8'h01);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
